bus_uart: RTL and testbench
===========================

Name: bus_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the shared peripheral bus (bus_in/bus_out bundles defined in bus_params.v).
- Provides a programmable baud divider, a one-byte transmitter and a one-byte receive buffer.
- Serial lines go to pads; the bench loops ser_tx back to ser_rx.

Parameters:
- BUS_ADDR, 32'h0200_0004: base byte address of the register window.
- CPU_FREQ, 32'd50_000_000: clock frequency in Hz.
- BAUD, 32'd115200: reset baud rate. Reset divider = CPU_FREQ/BAUD, evaluated at elaboration.

Ports:
- clk  input  1  clock. Top level ties it to bus_in[BUS_FIELD_CLK].
- reset  input  1  synchronous, active-high reset. Top level drives !bus_in[BUS_FIELD_RESET_L].
- bus_in  input  BUS_IN_WIDTH  fields: BE[3:0], ADDR[31:0], WR_DATA[31:0], RD_REQ, WR_REQ. The CLK and RESET_L fields are ignored inside the block.
- bus_out  output  BUS_OUT_WIDTH  fields: RD_DATA[31:0], RD_ACK. All zero when this block is not acknowledging, so bus_out vectors may be OR-ed.
- ser_tx  output  1  serial transmit. Idle high.
- ser_rx  input  1  serial receive. Passed through a 2-flop synchronizer.
- recv_buf_valid  output  1  high while the receive buffer holds an unread byte.

Behaviour:
Register map (word addresses; an access decodes only on an exact match):
- BUS_ADDR+0, DIV, R/W: baud divider, 32 bits.
  - Writes honour BE per byte lane.
  - A resulting value below 2 is stored as 2.
- BUS_ADDR+4, DATA:
  - Write with BE[0]=1 loads WR_DATA[7:0] and starts transmission if the transmitter is idle. If busy, the write is dropped.
  - Read returns {24'h0, rx_byte} and clears recv_buf_valid. If the buffer is empty the read returns 32'hFFFF_FFFF.
- BUS_ADDR+8, STATUS, read-only:
  - bit0 tx_busy.
  - bit1 recv_buf_valid.
  - bit2 overrun, sticky, cleared by the STATUS read.
  - bit3 framing error, sticky, cleared by the STATUS read.

Bus timing:
- RD_ACK and RD_DATA are registered: one cycle after a RD_REQ that hits.
- Writes take effect on the clock edge that samples WR_REQ. No write acknowledge.
- Unmapped offsets are ignored and are not acknowledged.

Transmitter:
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts DIV clocks.
- ser_tx goes low on the cycle after the accepting write.
- tx_busy is high from that cycle until the end of the stop bit.
- A DIV change mid-frame applies from the next bit.

Receiver state machine: IDLE -> START -> DATA(8) -> STOP.
- IDLE -> START on a synchronized falling edge.
- START: sample at DIV/2. If the line is high, return to IDLE (glitch).
- DATA: sample every DIV clocks, 8 bits.
- STOP:
  - Stop bit = 1: write the byte to the buffer and set recv_buf_valid.
  - Stop bit = 0: set framing error, discard the byte, and wait for the line to go high before re-entering IDLE.
- A byte arriving while the buffer is valid overwrites it and sets overrun.
- If a DATA read and a new byte land on the same cycle, the new byte wins and recv_buf_valid stays 1.

Reset values:
- ser_tx=1, tx_busy=0, recv_buf_valid=0, DIV=CPU_FREQ/BAUD, error flags=0, bus_out=0, both FSMs idle.
- Reset mid-frame aborts immediately; ser_tx returns high the next cycle.

Optional Feature:
- Macro BUS_UART_RX_FIFO_EN.
- Defined: the receive buffer becomes a 4-entry FIFO.
  - recv_buf_valid means the FIFO is not empty.
  - A DATA read pops one entry.
  - A byte arriving when the FIFO is full is dropped (the newest is lost) and sets overrun.
  - STATUS bits [6:4] give the occupancy count.
- Undefined: single-byte buffer as above; STATUS bits [6:4] read 0.

Decomposition:
- bus_params.v (shared include) holds BUS_IN_WIDTH, BUS_OUT_WIDTH, the BUS_FIELD_*, BUS_ADDR_*, BUS_WR_DATA_*, BUS_RD_DATA_* and BUS_FIELD_RD_ACK constants.
- Register offsets (UART_DIV=0, UART_DATA=4, UART_STATUS=8) live in the same include.
- One natural sub-module: uart_rx_core (synchronizer + receive FSM, outputs byte+strobe+framing error). The transmitter and register decode stay in bus_uart.

Test Plan:
- Reset with CPU_FREQ=1152000, BAUD=115200 -> DIV reads 10; ser_tx=1; recv_buf_valid=0; STATUS=0.
- Write 0x41 to 0x02000008 with ser_tx looped to ser_rx -> ser_tx low for 10 clocks, then pattern 1,0,0,0,0,0,1,0, then stop high. recv_buf_valid rises after about 95 clocks. DATA read returns 0x00000041 and clears valid.
- DATA read when empty -> 0xFFFFFFFF, one-cycle RD_ACK. Access to an unmapped address -> no ACK, bus_out=0.
- Second DATA write while tx_busy -> dropped; exactly one frame on ser_tx.
- Two bytes received without a read -> second byte read back, STATUS bit2=1; after the STATUS read, bit2=0. With BUS_UART_RX_FIFO_EN: both bytes read back in order, count reaches 2.
- Write DIV=1 -> DIV reads 2. Hold ser_rx low through the stop bit -> framing bit3=1, recv_buf_valid stays 0.

Source files
------------

// File: rtl/bus_uart_pkg.sv
// Shared bus field layout, register offsets, FSM state types and helpers for bus_uart.
// Bus fields are flat bit positions inside the bus_in / bus_out vectors.
package bus_uart_pkg;

    localparam int BUS_FIELD_CLK     = 0;
    localparam int BUS_FIELD_RESET_L = 1;
    localparam int BUS_FIELD_RD_REQ  = 2;
    localparam int BUS_FIELD_WR_REQ  = 3;
    localparam int BUS_BE_LO         = 4;
    localparam int BUS_BE_HI         = 7;
    localparam int BUS_ADDR_LO       = 8;
    localparam int BUS_ADDR_HI       = 39;
    localparam int BUS_WR_DATA_LO    = 40;
    localparam int BUS_WR_DATA_HI    = 71;
    localparam int BUS_IN_WIDTH      = 72;

    localparam int BUS_RD_DATA_LO    = 0;
    localparam int BUS_RD_DATA_HI    = 31;
    localparam int BUS_FIELD_RD_ACK  = 32;
    localparam int BUS_OUT_WIDTH     = 33;

    localparam logic [31:0] UART_DIV    = 32'd0;
    localparam logic [31:0] UART_DATA   = 32'd4;
    localparam logic [31:0] UART_STATUS = 32'd8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // A divider below 2 would leave no mid-bit sample point in the receiver.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction

endpackage

// File: rtl/bus_uart_rx_core.sv
// uart_rx_core: 2-flop synchronizer plus 8N1 receive FSM.
// Emits a one-cycle strobe with the byte, or a framing-error strobe.
module uart_rx_core
    import bus_uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ser_rx,
    input  logic [31:0] div,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        rx_frame_err
);

    rx_state_t   state_r, state_nx;
    logic        sync1_r, sync2_r, prev_r;
    logic [31:0] cnt_r, cnt_nx;
    logic [2:0]  bit_r, bit_nx;
    logic [7:0]  shift_r, shift_nx;
    logic [7:0]  byte_r, byte_nx;
    logic        strobe_r, strobe_nx;
    logic        ferr_r, ferr_nx;
    logic [31:0] half_s;

    assign half_s       = div >> 1;
    assign rx_byte      = byte_r;
    assign rx_strobe    = strobe_r;
    assign rx_frame_err = ferr_r;

    // Synchronizer, edge-detect history and FSM/datapath state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            prev_r   <= 1'b1;
            state_r  <= RX_IDLE;
            cnt_r    <= 32'd0;
            bit_r    <= 3'd0;
            shift_r  <= 8'd0;
            byte_r   <= 8'd0;
            strobe_r <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            sync1_r  <= ser_rx;
            sync2_r  <= sync1_r;
            prev_r   <= sync2_r;
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            bit_r    <= bit_nx;
            shift_r  <= shift_nx;
            byte_r   <= byte_nx;
            strobe_r <= strobe_nx;
            ferr_r   <= ferr_nx;
        end
    end

    // Receive next-state and sampling logic.
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        bit_nx    = bit_r;
        shift_nx  = shift_r;
        byte_nx   = byte_r;
        strobe_nx = 1'b0;
        ferr_nx   = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_nx = 32'd0;
                if (prev_r && !sync2_r) begin
                    state_nx = RX_START;
                end else begin
                    state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r >= half_s - 32'd1) begin
                    cnt_nx   = 32'd0;
                    bit_nx   = 3'd0;
                    state_nx = sync2_r ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nx = cnt_r + 32'd1;
                end
            end
            RX_DATA: begin
                if (cnt_r >= div - 32'd1) begin
                    cnt_nx   = 32'd0;
                    shift_nx = {sync2_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_nx = RX_STOP;
                    end else begin
                        bit_nx = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt_r + 32'd1;
                end
            end
            RX_STOP: begin
                if (cnt_r >= div - 32'd1) begin
                    cnt_nx = 32'd0;
                    if (sync2_r) begin
                        byte_nx   = shift_r;
                        strobe_nx = 1'b1;
                        state_nx  = RX_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_nx = cnt_r + 32'd1;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_r) begin
                    state_nx = RX_IDLE;
                end else begin
                    state_nx = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_nx = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 UART (DIV / DATA / STATUS) on the peripheral bus.
// Define BUS_UART_RX_FIFO_EN to replace the single receive buffer with a 4-entry FIFO.
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BUS_ADDR = 32'h0200_0004,
    parameter logic [31:0] CPU_FREQ = 32'd50_000_000,
    parameter logic [31:0] BAUD     = 32'd115200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    output logic                     ser_tx,
    input  logic                     ser_rx,
    output logic                     recv_buf_valid
);

    localparam logic [31:0] DIV_RESET = clamp_div(CPU_FREQ / BAUD);

    logic        rd_req_s, wr_req_s;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wdata_s;
    logic        hit_div_s, hit_data_s, hit_stat_s;
    logic        wr_div_s, wr_data_s, rd_data_hit_s, rd_stat_s;
    logic        unused_bus_s;

    assign rd_req_s      = bus_in[BUS_FIELD_RD_REQ];
    assign wr_req_s      = bus_in[BUS_FIELD_WR_REQ];
    assign be_s          = bus_in[BUS_BE_HI:BUS_BE_LO];
    assign addr_s        = bus_in[BUS_ADDR_HI:BUS_ADDR_LO];
    assign wdata_s       = bus_in[BUS_WR_DATA_HI:BUS_WR_DATA_LO];
    assign unused_bus_s  = bus_in[BUS_FIELD_CLK] ^ bus_in[BUS_FIELD_RESET_L];

    assign hit_div_s     = (addr_s == BUS_ADDR + UART_DIV);
    assign hit_data_s    = (addr_s == BUS_ADDR + UART_DATA);
    assign hit_stat_s    = (addr_s == BUS_ADDR + UART_STATUS);
    assign wr_div_s      = wr_req_s && hit_div_s;
    assign wr_data_s     = wr_req_s && hit_data_s && be_s[0];
    assign rd_data_hit_s = rd_req_s && hit_data_s;
    assign rd_stat_s     = rd_req_s && hit_stat_s;

    logic [31:0] div_r;
    logic        rd_ack_r, rd_ack_nx;
    logic [31:0] rd_data_r, rd_data_nx;
    logic        overrun_r, ferr_r, rx_valid_r;
    logic        overrun_set_s;
    logic [7:0]  rx_head_s;
    logic [2:0]  occ_s;
    logic [7:0]  rx_byte_s;
    logic        rx_strobe_s, rx_frame_err_s;

    // Transmitter state
    tx_state_t   tx_state_r, tx_state_nx;
    logic [31:0] tx_cnt_r, tx_cnt_nx, tx_div_r, tx_div_nx;
    logic [2:0]  tx_bit_r, tx_bit_nx;
    logic [7:0]  tx_shift_r, tx_shift_nx;
    logic        ser_tx_r, ser_tx_nx;
    logic        tx_busy_s;

    assign tx_busy_s = (tx_state_r != TX_IDLE);

    // Transmitter FSM state and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 32'd0;
            tx_div_r   <= DIV_RESET;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            ser_tx_r   <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nx;
            tx_cnt_r   <= tx_cnt_nx;
            tx_div_r   <= tx_div_nx;
            tx_bit_r   <= tx_bit_nx;
            tx_shift_r <= tx_shift_nx;
            ser_tx_r   <= ser_tx_nx;
        end
    end

    // Transmitter next-state; the bit length is latched at every bit boundary.
    always_comb begin
        tx_state_nx = tx_state_r;
        tx_cnt_nx   = tx_cnt_r;
        tx_div_nx   = tx_div_r;
        tx_bit_nx   = tx_bit_r;
        tx_shift_nx = tx_shift_r;
        ser_tx_nx   = ser_tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (wr_data_s) begin
                    tx_state_nx = TX_START;
                    tx_cnt_nx   = 32'd0;
                    tx_div_nx   = div_r;
                    tx_bit_nx   = 3'd0;
                    tx_shift_nx = wdata_s[7:0];
                    ser_tx_nx   = 1'b0;
                end else begin
                    ser_tx_nx = 1'b1;
                end
            end
            TX_START, TX_DATA, TX_STOP: begin
                if (tx_cnt_r >= tx_div_r - 32'd1) begin
                    tx_cnt_nx = 32'd0;
                    tx_div_nx = div_r;
                    if (tx_state_r == TX_START) begin
                        tx_state_nx = TX_DATA;
                        ser_tx_nx   = tx_shift_r[0];
                    end else if (tx_state_r == TX_DATA) begin
                        if (tx_bit_r == 3'd7) begin
                            tx_state_nx = TX_STOP;
                            ser_tx_nx   = 1'b1;
                        end else begin
                            tx_bit_nx   = tx_bit_r + 3'd1;
                            tx_shift_nx = tx_shift_r >> 1;
                            ser_tx_nx   = tx_shift_r[1];
                        end
                    end else begin
                        tx_state_nx = TX_IDLE;
                        ser_tx_nx   = 1'b1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt_r + 32'd1;
                end
            end
            default: begin
                tx_state_nx = TX_IDLE;
                ser_tx_nx   = 1'b1;
            end
        endcase
    end

    uart_rx_core u_rx (
        .clk          (clk),
        .reset        (reset),
        .ser_rx       (ser_rx),
        .div          (div_r),
        .rx_byte      (rx_byte_s),
        .rx_strobe    (rx_strobe_s),
        .rx_frame_err (rx_frame_err_s)
    );

`ifdef BUS_UART_RX_FIFO_EN
    logic [7:0] fifo_r [0:3];
    logic [1:0] wptr_r, rptr_r;
    logic [2:0] count_r, count_nx_s;
    logic       push_s, pop_s;

    // FIFO push/pop decision; a full FIFO drops the newest byte.
    always_comb begin
        push_s        = rx_strobe_s && (count_r != 3'd4);
        pop_s         = rd_data_hit_s && (count_r != 3'd0);
        count_nx_s    = count_r + {2'b00, push_s} - {2'b00, pop_s};
        rx_head_s     = fifo_r[rptr_r];
        occ_s         = count_r;
        overrun_set_s = rx_strobe_s && (count_r == 3'd4);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_r[i] <= 8'd0;
            end
            wptr_r     <= 2'd0;
            rptr_r     <= 2'd0;
            count_r    <= 3'd0;
            rx_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wptr_r] <= rx_byte_s;
                wptr_r         <= wptr_r + 2'd1;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 2'd1;
            end else begin
                rptr_r <= rptr_r;
            end
            count_r    <= count_nx_s;
            rx_valid_r <= (count_nx_s != 3'd0);
        end
    end
`else
    logic [7:0] rx_data_r;

    // Single buffer: only an unread byte that gets overwritten counts as overrun.
    always_comb begin
        rx_head_s     = rx_data_r;
        occ_s         = 3'd0;
        overrun_set_s = rx_strobe_s && rx_valid_r && !rd_data_hit_s;
    end

    // Single-byte receive buffer; a new byte wins over a same-cycle read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
        end else if (rx_strobe_s) begin
            rx_data_r  <= rx_byte_s;
            rx_valid_r <= 1'b1;
        end else if (rd_data_hit_s) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end
`endif

    // Divider register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= DIV_RESET;
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            if (wr_div_s) begin
                div_r <= clamp_div(merge_lanes(div_r, wdata_s, be_s));
            end else begin
                div_r <= div_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (rd_stat_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (rx_frame_err_s) begin
                ferr_r <= 1'b1;
            end else if (rd_stat_s) begin
                ferr_r <= 1'b0;
            end else begin
                ferr_r <= ferr_r;
            end
        end
    end

    // Read mux; data stays zero unless acknowledging so bus_out can be OR-ed.
    always_comb begin
        rd_ack_nx  = 1'b0;
        rd_data_nx = 32'd0;
        if (rd_req_s && hit_div_s) begin
            rd_ack_nx  = 1'b1;
            rd_data_nx = div_r;
        end else if (rd_data_hit_s) begin
            rd_ack_nx  = 1'b1;
            rd_data_nx = rx_valid_r ? {24'd0, rx_head_s} : 32'hFFFF_FFFF;
        end else if (rd_stat_s) begin
            rd_ack_nx  = 1'b1;
            rd_data_nx = {25'd0, occ_s, ferr_r, overrun_r, rx_valid_r, tx_busy_s};
        end else begin
            rd_ack_nx  = 1'b0;
            rd_data_nx = 32'd0;
        end
    end

    // Registered read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= 32'd0;
        end else begin
            rd_ack_r  <= rd_ack_nx;
            rd_data_r <= rd_data_nx;
        end
    end

    // Pack the response fields into bus_out.
    always_comb begin
        bus_out                                = '0;
        bus_out[BUS_RD_DATA_HI:BUS_RD_DATA_LO] = rd_data_r;
        bus_out[BUS_FIELD_RD_ACK]              = rd_ack_r;
    end

    assign ser_tx         = ser_tx_r;
    assign recv_buf_valid = rx_valid_r;

endmodule

// File: tb/tb_bus_uart.sv
// Directed self-checking bench for bus_uart with ser_tx looped back to ser_rx.
// Expectations for STATUS/DATA follow BUS_UART_RX_FIFO_EN when it is defined.
module tb_bus_uart;
    import bus_uart_pkg::*;

    localparam logic [31:0] BASE  = 32'h0200_0004;
    localparam logic [31:0] A_DIV = BASE + 32'd0;
    localparam logic [31:0] A_DAT = BASE + 32'd4;
    localparam logic [31:0] A_STA = BASE + 32'd8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;
    logic                     ser_tx, ser_rx, recv_buf_valid;
    logic                     rd_req = 1'b0, wr_req = 1'b0;
    logic [3:0]               be = 4'd0;
    logic [31:0]              addr = 32'd0, wdata = 32'd0;
    logic                     loop_en = 1'b1, rx_drive = 1'b1;
    int                       n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign ser_rx = loop_en ? ser_tx : rx_drive;

    always_comb begin
        bus_in                                 = '0;
        bus_in[BUS_FIELD_CLK]                  = clk;
        bus_in[BUS_FIELD_RESET_L]              = ~reset;
        bus_in[BUS_FIELD_RD_REQ]               = rd_req;
        bus_in[BUS_FIELD_WR_REQ]               = wr_req;
        bus_in[BUS_BE_HI:BUS_BE_LO]            = be;
        bus_in[BUS_ADDR_HI:BUS_ADDR_LO]        = addr;
        bus_in[BUS_WR_DATA_HI:BUS_WR_DATA_LO]  = wdata;
    end

    bus_uart #(.BUS_ADDR(BASE), .CPU_FREQ(32'd1_152_000), .BAUD(32'd115200)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .ser_tx         (ser_tx),
        .ser_rx         (ser_rx),
        .recv_buf_valid (recv_buf_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr_req = 1'b1;
        @(posedge clk);
        #1;
        wr_req = 1'b0; be = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                            output logic ack, output logic ack_after);
        @(negedge clk);
        addr = a; rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        d   = bus_out[BUS_RD_DATA_HI:BUS_RD_DATA_LO];
        ack = bus_out[BUS_FIELD_RD_ACK];
        @(posedge clk);
        #1;
        ack_after = bus_out[BUS_FIELD_RD_ACK];
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (recv_buf_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        ack, ack2, ok;
        logic [7:0]  tx_byte;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus_read(A_DIV, d, ack, ack2);
        check_val("reset_div", d, 32'd10);
        check_val("reset_div_ack", {31'd0, ack}, 32'd1);
        check_val("reset_ser_tx", {31'd0, ser_tx}, 32'd1);
        check_val("reset_valid", {31'd0, recv_buf_valid}, 32'd0);
        bus_read(A_STA, d, ack, ack2);
        check_val("reset_status", d, 32'd0);

        // Frame of 0x41 with loopback
        tx_byte = 8'h41;
        bus_write(A_DAT, 32'h0000_0041, 4'b0001);
        check_val("tx_start_edge", {31'd0, ser_tx}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_val("tx_start_mid", {31'd0, ser_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(posedge clk);
            #1;
            check_val("tx_bit", {31'd0, ser_tx}, {31'd0, tx_byte[i]});
        end
        repeat (10) @(posedge clk);
        #1;
        check_val("tx_stop", {31'd0, ser_tx}, 32'd1);
        wait_valid(200, ok);
        check_val("rx_valid_rise", {31'd0, ok}, 32'd1);
        bus_read(A_DAT, d, ack, ack2);
        check_val("rx_data_41", d, 32'h0000_0041);
        check_val("rx_valid_clr", {31'd0, recv_buf_valid}, 32'd0);

        // Empty read and unmapped access
        bus_read(A_DAT, d, ack, ack2);
        check_val("empty_data", d, 32'hFFFF_FFFF);
        check_val("empty_ack", {31'd0, ack}, 32'd1);
        check_val("ack_one_cycle", {31'd0, ack2}, 32'd0);
        bus_read(BASE + 32'd12, d, ack, ack2);
        check_val("unmapped_ack", {31'd0, ack}, 32'd0);
        check_val("unmapped_data", d, 32'd0);

        // Write while busy is dropped
        bus_write(A_DAT, 32'h0000_0055, 4'b0001);
        repeat (3) @(posedge clk);
        bus_write(A_DAT, 32'h0000_00AA, 4'b0001);
        bus_read(A_STA, d, ack, ack2);
        check_val("busy_status", d, 32'h0000_0001);
        wait_valid(200, ok);
        check_val("drop_rx_valid", {31'd0, ok}, 32'd1);
        bus_read(A_DAT, d, ack, ack2);
        check_val("drop_rx_data", d, 32'h0000_0055);
        repeat (150) @(posedge clk);
        #1;
        check_val("drop_no_second", {31'd0, recv_buf_valid}, 32'd0);
        bus_read(A_STA, d, ack, ack2);
        check_val("drop_idle_status", d, 32'd0);

        // Two bytes without a read
        bus_write(A_DAT, 32'h0000_0012, 4'b0001);
        repeat (110) @(posedge clk);
        bus_write(A_DAT, 32'h0000_0034, 4'b0001);
        repeat (120) @(posedge clk);
`ifdef BUS_UART_RX_FIFO_EN
        bus_read(A_STA, d, ack, ack2);
        check_val("two_status", d, 32'h0000_0022);
        bus_read(A_STA, d, ack, ack2);
        check_val("two_status2", d, 32'h0000_0022);
        bus_read(A_DAT, d, ack, ack2);
        check_val("fifo_first", d, 32'h0000_0012);
        bus_read(A_DAT, d, ack, ack2);
        check_val("fifo_second", d, 32'h0000_0034);
`else
        bus_read(A_STA, d, ack, ack2);
        check_val("two_status", d, 32'h0000_0006);
        bus_read(A_STA, d, ack, ack2);
        check_val("two_status2", d, 32'h0000_0002);
        bus_read(A_DAT, d, ack, ack2);
        check_val("overrun_data", d, 32'h0000_0034);
`endif
        check_val("two_valid_clr", {31'd0, recv_buf_valid}, 32'd0);

        // Divider clamp and byte-lane masking
        bus_write(A_DIV, 32'h0000_0001, 4'b1111);
        bus_read(A_DIV, d, ack, ack2);
        check_val("div_clamp", d, 32'd2);
        bus_write(A_DIV, 32'hFFFF_FF0A, 4'b0001);
        bus_read(A_DIV, d, ack, ack2);
        check_val("div_lane0", d, 32'd10);

        // Framing error: line held low through the stop bit
        rx_drive = 1'b0;
        loop_en  = 1'b0;
        repeat (120) @(posedge clk);
        rx_drive = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("ferr_valid", {31'd0, recv_buf_valid}, 32'd0);
        bus_read(A_STA, d, ack, ack2);
        check_val("ferr_status", d, 32'h0000_0008);
        bus_read(A_STA, d, ack, ack2);
        check_val("ferr_cleared", d, 32'd0);
        loop_en = 1'b1;

        // Reset mid-frame
        bus_write(A_DAT, 32'h0000_0000, 4'b0001);
        repeat (15) @(posedge clk);
        #1;
        check_val("midframe_low", {31'd0, ser_tx}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midframe_reset_tx", {31'd0, ser_tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_STA, d, ack, ack2);
        check_val("midframe_status", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
